dec_sample_buffer: RTL and testbench
====================================

Name: dec_sample_buffer

Overview:
- Output stage directly downstream of the sinc3 decimator (sinc_filter); consumes one decimated 20-bit signed sample per IN_VALID strobe.
- Scales each sample by an arithmetic left shift and saturates it to 16-bit signed.
- Buffers samples in a first-word-fall-through FIFO behind a valid/ready handshake, so the Python/DPI side or a downstream filter can drain them at its own rate.
- Reports occupancy, sticky overflow and sticky saturation status.

Parameters:
- DIN_W, 20, input sample width (signed); matches the sinc3 difference-stage width.
- DOUT_W, 16, output sample width (signed).
- SHIFT, 3, left-shift applied before saturation; with decimation 16, full scale is ±4096, so SHIFT=3 gives ±32768.
- DEPTH, 8, FIFO entries; must be a power of 2, minimum 2.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RST  input  1  reset, synchronous, active-high.
- IN_VALID  input  1  one-cycle strobe: IN_DATA holds a new decimated sample; may be asserted on consecutive cycles.
- IN_DATA  input  DIN_W  signed decimated sample.
- OUT_READY  input  1  consumer accepts OUT_DATA this cycle.
- OUT_VALID  output  1  FIFO head valid.
- OUT_DATA  output  DOUT_W  signed FIFO head sample.
- LEVEL  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- OVERFLOW  output  1  sticky: a sample was dropped because the FIFO was full.
- SAT_FLAG  output  1  sticky: at least one sample saturated.
- CLR_FLAGS  input  1  synchronous clear of OVERFLOW and SAT_FLAG.

Behaviour:
- Reset: on RST=1 at a rising edge, the stage register is emptied and FIFO pointers are zeroed. Outputs: OUT_VALID=0, OUT_DATA=0, LEVEL=0, OVERFLOW=0, SAT_FLAG=0. An in-flight stage sample is discarded. RST overrides all other inputs.
- Stage 1, scale/saturate (registered): on an edge with IN_VALID=1:
  - Compute wide = sign-extended IN_DATA <<< SHIFT, in DIN_W+SHIFT bits; no bits are lost before clamping.
  - If wide > 2^(DOUT_W-1)-1, clamp to 32767; if wide < -2^(DOUT_W-1), clamp to -32768. Either case sets SAT_FLAG.
  - Store the result in stage_data and set stage_vld=1.
  - On an edge with IN_VALID=0, stage_vld is cleared.
- Stage 2, FIFO write: at the edge after capture, if stage_vld=1, the stage sample is pushed.
  - Push is accepted if LEVEL<DEPTH, or LEVEL==DEPTH with a pop on the same edge.
  - Otherwise the sample is dropped, OVERFLOW is set, and FIFO contents are unchanged.
- Latency: IN_VALID at edge N → OUT_VALID=1 and OUT_DATA valid after edge N+1 when the FIFO was empty. That is 2 edges from input to visible output.
- Pop: an edge with OUT_VALID=1 and OUT_READY=1 removes the head. OUT_DATA then shows the next entry (FWFT). OUT_READY while OUT_VALID=0 has no effect.
- Push and pop on the same edge: LEVEL is unchanged. This is legal at LEVEL=DEPTH and at any LEVEL≥1. With LEVEL=0, no pop occurs.
- Pointers: read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. LEVEL is kept as an explicit counter.
- OUT_DATA holds its last value when the FIFO is empty; its value is don't-care when OUT_VALID=0, except after reset, when it is 0.
- CLR_FLAGS: clears OVERFLOW and SAT_FLAG. If a new overflow or saturation event occurs on the same edge, the set wins.
- Ordering: samples leave strictly in arrival order; none are reordered or duplicated.

Decomposition:
- Package dec_pkg holds:
  - localparams SINC_DEC_RATIO=16, SINC_W=20, SAMPLE_W=16.
  - typedef logic signed [SAMPLE_W-1:0] sample_t.
  - function sat_shift(input signed value, shift) returning sample_t plus a saturation bit.
- Sub-module sync_fifo_fwft, parameterised on width and DEPTH. It contains the storage, pointers, LEVEL and full/empty logic. The top level holds the stage register, saturation and sticky flags.

Test Plan:
1. IN_DATA=100, SHIFT=3, OUT_READY=1 → OUT_DATA=800 two edges after the strobe; OUT_VALID high for 1 cycle; SAT_FLAG=0.
2. IN_DATA=4096 → OUT_DATA=32767, SAT_FLAG=1. Then IN_DATA=-4096 → OUT_DATA=-32768 with no new saturation; after CLR_FLAGS, SAT_FLAG=0.
3. OUT_READY=0; strobe values 1..9 (×8 = 8..72) → LEVEL=8 and OVERFLOW=1 after the 9th strobe. Then drain with OUT_READY=1 → outputs 8,16,...,64 in order, then OUT_VALID=0 and LEVEL=0.
4. FIFO full (LEVEL=8); IN_VALID and OUT_READY on the same cycle → head popped, new sample accepted, LEVEL stays 8, OVERFLOW unchanged.
5. One strobe every 16 cycles (sinc rate), 200 samples, with OUT_READY toggled randomly ≥50% → no overflow, all 200 samples received in order against the scoreboard.
6. RST pulsed with LEVEL=5 and a sample in the stage register → next cycle LEVEL=0, OUT_VALID=0, OUT_DATA=0, flags 0; the first post-reset strobe emerges normally.

Source files
------------

// File: rtl/dec_pkg.sv
// Shared constants, sample type and the scale/saturate helper for the
// decimator output path.
package dec_pkg;

    localparam int SINC_DEC_RATIO = 16;
    localparam int SINC_W         = 20;
    localparam int SAMPLE_W       = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef struct packed {
        sample_t data;
        logic    sat;
    } sat_res_t;

    // Arithmetic left shift followed by a clamp to SAMPLE_W signed.
    // The input is taken pre-sign-extended to 32 bits and widened to 64 bits
    // so no bits are lost before the clamp for any shift up to 32.
    function automatic sat_res_t sat_shift(input logic signed [31:0] value,
                                           input int unsigned         shift);
        logic signed [63:0] wide;
        logic signed [63:0] smax;
        logic signed [63:0] smin;
        sat_res_t           r;
        smax = (64'sd1 <<< (SAMPLE_W - 1)) - 64'sd1;
        smin = -(64'sd1 <<< (SAMPLE_W - 1));
        wide = {{32{value[31]}}, value};
        wide = wide <<< shift;
        if (wide > smax) begin
            r.data = sample_t'(smax);
            r.sat  = 1'b1;
        end else if (wide < smin) begin
            r.data = sample_t'(smin);
            r.sat  = 1'b1;
        end else begin
            r.data = sample_t'(wide);
            r.sat  = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/dec_sample_buffer_fifo.sv
// First-word-fall-through synchronous FIFO with an explicit occupancy counter.
// DEPTH must be a power of two (pointers wrap naturally) and at least 2.
module sync_fifo_fwft #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop_req,
    output logic [WIDTH-1:0]         rdata,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     accepted
);
    import dec_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             full;
    logic             pop;

    assign valid    = (level != '0);
    assign full     = (level == LW'(DEPTH));
    assign pop      = pop_req && valid;
    // A full FIFO still takes a write when the head leaves on the same edge.
    assign accepted = push && (!full || pop);
    assign rdata    = mem[rptr];

    // Storage is cleared on reset so the head reads 0 until the first write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (accepted) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers and occupancy counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (accepted) wptr <= wptr + PW'(1);
            if (pop)      rptr <= rptr + PW'(1);
            case ({accepted, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/dec_sample_buffer.sv
// Output stage behind the sinc3 decimator: scale and saturate each sample,
// queue it in a FWFT FIFO and report occupancy plus sticky error flags.
// DOUT_W is expected to equal dec_pkg::SAMPLE_W.
module dec_sample_buffer
    import dec_pkg::*;
#(
    parameter int          DIN_W  = 20,
    parameter int          DOUT_W = 16,
    parameter int unsigned SHIFT  = 3,
    parameter int          DEPTH  = 8
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        IN_VALID,
    input  logic signed [DIN_W-1:0]     IN_DATA,
    input  logic                        OUT_READY,
    output logic                        OUT_VALID,
    output logic [DOUT_W-1:0]           OUT_DATA,
    output logic [$clog2(DEPTH):0]      LEVEL,
    output logic                        OVERFLOW,
    output logic                        SAT_FLAG,
    input  logic                        CLR_FLAGS
);

    sat_res_t res;
    sample_t  stage_data;
    logic     stage_vld;
    logic     accepted;

    assign res = sat_shift(32'(IN_DATA), SHIFT);

    // Stage register: capture the scaled sample on each input strobe.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stage_vld  <= 1'b0;
            stage_data <= '0;
        end else begin
            stage_vld <= IN_VALID;
            if (IN_VALID) stage_data <= res.data;
        end
    end

    // Sticky flags; a new event on the clear edge wins over the clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            SAT_FLAG <= 1'b0;
            OVERFLOW <= 1'b0;
        end else begin
            if (IN_VALID && res.sat) SAT_FLAG <= 1'b1;
            else if (CLR_FLAGS)      SAT_FLAG <= 1'b0;
            if (stage_vld && !accepted) OVERFLOW <= 1'b1;
            else if (CLR_FLAGS)         OVERFLOW <= 1'b0;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (DOUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (CLK),
        .rst      (RST),
        .push     (stage_vld),
        .wdata    (DOUT_W'(stage_data)),
        .pop_req  (OUT_READY),
        .rdata    (OUT_DATA),
        .valid    (OUT_VALID),
        .level    (LEVEL),
        .accepted (accepted)
    );

endmodule

// File: tb/tb_dec_sample_buffer.sv
// Scoreboard bench for dec_sample_buffer: expected samples are queued when
// strobed and compared when the consumer pops them.
module tb_dec_sample_buffer;

    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic               IN_VALID = 1'b0;
    logic signed [19:0] IN_DATA = '0;
    logic               OUT_READY = 1'b0;
    logic               OUT_VALID;
    logic [15:0]        OUT_DATA;
    logic [3:0]         LEVEL;
    logic               OVERFLOW;
    logic               SAT_FLAG;
    logic               CLR_FLAGS = 1'b0;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] sb[$];

    dec_sample_buffer dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_DATA   (IN_DATA),
        .OUT_READY (OUT_READY),
        .OUT_VALID (OUT_VALID),
        .OUT_DATA  (OUT_DATA),
        .LEVEL     (LEVEL),
        .OVERFLOW  (OVERFLOW),
        .SAT_FLAG  (SAT_FLAG),
        .CLR_FLAGS (CLR_FLAGS)
    );

    always #5 CLK = ~CLK;

    // Reference scaling: multiply by 8 and clamp to 16-bit signed.
    function automatic logic [15:0] exp_of(input int v);
        int p;
        p = v * 8;
        if (p > 32767) p = 32767;
        if (p < -32768) p = -32768;
        return 16'(p);
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick(); tick();
        RST = 1'b0;
        checks++;
        if ({OUT_VALID, OUT_DATA, LEVEL, OVERFLOW, SAT_FLAG} !== 23'd0) begin
            errors++;
            $display("FAIL reset_state: got v=%0b d=%0d l=%0d ov=%0b sat=%0b, want all 0",
                     OUT_VALID, OUT_DATA, LEVEL, OVERFLOW, SAT_FLAG);
        end
    endtask

    task automatic test_basic();
        OUT_READY = 1'b1;
        IN_VALID = 1'b1; IN_DATA = 20'sd100; sb.push_back(exp_of(100));
        tick();
        IN_VALID = 1'b0;
        checks++;
        if (OUT_VALID !== 1'b0) begin
            errors++; $display("FAIL basic_latency: OUT_VALID=%0b after 1 edge, want 0", OUT_VALID);
        end
        tick();
        checks++;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== sb[0]) begin
            errors++; $display("FAIL basic_out: v=%0b d=%0d, want v=1 d=%0d", OUT_VALID, $signed(OUT_DATA), $signed(sb[0]));
        end
        void'(sb.pop_front());
        tick();
        checks++;
        if (OUT_VALID !== 1'b0 || SAT_FLAG !== 1'b0) begin
            errors++; $display("FAIL basic_one_cycle: v=%0b sat=%0b, want 0 0", OUT_VALID, SAT_FLAG);
        end
    endtask

    task automatic test_saturation();
        OUT_READY = 1'b1;
        IN_VALID = 1'b1; IN_DATA = 20'sd4096;
        tick();
        IN_VALID = 1'b0;
        tick();
        checks++;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== exp_of(4096) || SAT_FLAG !== 1'b1) begin
            errors++; $display("FAIL sat_pos: v=%0b d=%0d sat=%0b, want 1 32767 1", OUT_VALID, $signed(OUT_DATA), SAT_FLAG);
        end
        CLR_FLAGS = 1'b1;
        tick();
        CLR_FLAGS = 1'b0;
        checks++;
        if (SAT_FLAG !== 1'b0) begin
            errors++; $display("FAIL sat_clear: SAT_FLAG=%0b, want 0", SAT_FLAG);
        end
        IN_VALID = 1'b1; IN_DATA = -20'sd4096;
        tick();
        IN_VALID = 1'b0;
        tick();
        checks++;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== exp_of(-4096) || SAT_FLAG !== 1'b0) begin
            errors++; $display("FAIL sat_neg_edge: v=%0b d=%0d sat=%0b, want 1 -32768 0", OUT_VALID, $signed(OUT_DATA), SAT_FLAG);
        end
        tick();
    endtask

    // Pop everything with OUT_READY held high, comparing against the scoreboard.
    task automatic drain(input string tag);
        int n;
        n = 0;
        OUT_READY = 1'b1;
        while (sb.size() != 0 && n < 40) begin
            if (OUT_VALID) begin
                checks++;
                if (OUT_DATA !== sb[0]) begin
                    errors++; $display("FAIL %s_order: got %0d want %0d", tag, $signed(OUT_DATA), $signed(sb[0]));
                end
                void'(sb.pop_front());
            end
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0 || OUT_VALID !== 1'b0 || LEVEL !== 4'd0) begin
            errors++; $display("FAIL %s_empty: left=%0d v=%0b level=%0d, want 0 0 0", tag, sb.size(), OUT_VALID, LEVEL);
        end
    endtask

    task automatic test_overflow();
        OUT_READY = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            IN_VALID = 1'b1; IN_DATA = 20'(i);
            if (i <= 8) sb.push_back(exp_of(i));
            tick();
        end
        IN_VALID = 1'b0;
        tick();
        checks++;
        if (LEVEL !== 4'd8 || OVERFLOW !== 1'b1) begin
            errors++; $display("FAIL overflow_full: level=%0d ov=%0b, want 8 1", LEVEL, OVERFLOW);
        end
        drain("overflow");
        CLR_FLAGS = 1'b1; tick(); CLR_FLAGS = 1'b0;
    endtask

    task automatic test_full_push_pop();
        OUT_READY = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            IN_VALID = 1'b1; IN_DATA = 20'(i); sb.push_back(exp_of(i));
            tick();
        end
        IN_VALID = 1'b0;
        tick();
        checks++;
        if (LEVEL !== 4'd8 || OVERFLOW !== 1'b0) begin
            errors++; $display("FAIL fullpp_fill: level=%0d ov=%0b, want 8 0", LEVEL, OVERFLOW);
        end
        IN_VALID = 1'b1; IN_DATA = 20'sd50; sb.push_back(exp_of(50));
        tick();
        IN_VALID = 1'b0; OUT_READY = 1'b1;
        checks++;
        if (OUT_DATA !== sb[0]) begin
            errors++; $display("FAIL fullpp_head: got %0d want %0d", $signed(OUT_DATA), $signed(sb[0]));
        end
        void'(sb.pop_front());
        tick();
        OUT_READY = 1'b0;
        checks++;
        if (LEVEL !== 4'd8 || OVERFLOW !== 1'b0 || OUT_DATA !== sb[0]) begin
            errors++; $display("FAIL fullpp_same_edge: level=%0d ov=%0b d=%0d, want 8 0 %0d",
                               LEVEL, OVERFLOW, $signed(OUT_DATA), $signed(sb[0]));
        end
        drain("fullpp");
    endtask

    task automatic test_stream();
        int sent;
        int got;
        int cyc;
        int v;
        sent = 0; got = 0; cyc = 0;
        while ((sent < 200 || sb.size() != 0) && cyc < 5000) begin
            IN_VALID  = (sent < 200) && (cyc % 16 == 0);
            OUT_READY = ($urandom_range(0, 3) != 0);
            if (IN_VALID) begin
                v = $urandom_range(0, 8000) - 4000;
                IN_DATA = 20'(v);
                sb.push_back(exp_of(v));
                sent++;
            end
            if (OUT_VALID && OUT_READY) begin
                checks++;
                if (sb.size() == 0 || OUT_DATA !== sb[0]) begin
                    errors++; $display("FAIL stream_order: sample %0d got %0d", got, $signed(OUT_DATA));
                end
                if (sb.size() != 0) void'(sb.pop_front());
                got++;
            end
            tick();
            cyc++;
        end
        IN_VALID = 1'b0;
        checks++;
        if (got != 200 || OVERFLOW !== 1'b0) begin
            errors++; $display("FAIL stream_count: got=%0d ov=%0b, want 200 0", got, OVERFLOW);
        end
        sb.delete();
    endtask

    task automatic test_mid_reset();
        OUT_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            IN_VALID = 1'b1; IN_DATA = (i == 0) ? 20'sd5000 : 20'(i);
            tick();
        end
        IN_VALID = 1'b0;
        tick();
        checks++;
        if (LEVEL !== 4'd5 || SAT_FLAG !== 1'b1) begin
            errors++; $display("FAIL midrst_setup: level=%0d sat=%0b, want 5 1", LEVEL, SAT_FLAG);
        end
        IN_VALID = 1'b1; IN_DATA = 20'sd7;
        tick();
        IN_VALID = 1'b0; RST = 1'b1;
        tick();
        RST = 1'b0;
        checks++;
        if ({OUT_VALID, OUT_DATA, LEVEL, OVERFLOW, SAT_FLAG} !== 23'd0) begin
            errors++; $display("FAIL midrst_state: v=%0b d=%0d l=%0d ov=%0b sat=%0b, want all 0",
                               OUT_VALID, OUT_DATA, LEVEL, OVERFLOW, SAT_FLAG);
        end
        tick(); tick();
        checks++;
        if (OUT_VALID !== 1'b0 || LEVEL !== 4'd0) begin
            errors++; $display("FAIL midrst_stage_dropped: v=%0b level=%0d, want 0 0", OUT_VALID, LEVEL);
        end
        sb.delete();
        OUT_READY = 1'b1;
        IN_VALID = 1'b1; IN_DATA = 20'sd3; sb.push_back(exp_of(3));
        tick();
        IN_VALID = 1'b0;
        tick();
        checks++;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== sb[0]) begin
            errors++; $display("FAIL midrst_first: v=%0b d=%0d, want 1 %0d", OUT_VALID, $signed(OUT_DATA), $signed(sb[0]));
        end
        void'(sb.pop_front());
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_overflow();
        test_full_push_pop();
        test_stream();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
